// File: rtl/memoria_instrucciones_cargable.sv
// Instruction memory for the fetch stage: 1-cycle stall-aware read port, HALT sweep after
// reset, and a byte-serial valid/ready program loader (MSB first) that fills words at runtime.
module memoria_instrucciones_cargable #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] direccion,
  input  logic                  stall,
  output logic [DATA_WIDTH-1:0] instruccion,
  output logic                  instr_valid,
  output logic                  busy,
  input  logic                  load_start,
  input  logic [7:0]            load_byte,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic                  load_end,
  output logic [ADDR_WIDTH:0]   load_count,
  output logic                  load_ovf
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int BPW   = DATA_WIDTH/8;
  localparam int BCW   = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [BCW-1:0] LAST_B = BCW'(BPW-1);

  typedef enum logic [1:0] {CLEAR, RUN, LOAD} state_t;
  state_t state, state_nx;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] clr_ptr, wr_ptr;
  logic [BCW-1:0]        byte_cnt;
  logic [DATA_WIDTH-1:0] asm_q, asm_nx;

  logic                  full, accept, word_done, flush, rd_en, we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;

  assign full      = (load_count == FULL);
  assign accept    = load_ready && load_valid;
  assign word_done = accept && (byte_cnt == LAST_B);
  // Partial word pending at load_end: either bytes already buffered or one arriving now
  assign flush     = (state == LOAD) && load_end && !full &&
                     ((accept && !word_done) || (!accept && byte_cnt != '0));

  // Assembly register is left-aligned so unfilled low bytes stay zero for the flush
  always_comb begin
    asm_nx = asm_q;
    if (accept)
      for (int i = 0; i < BPW; i++)
        if (byte_cnt == BCW'(i)) asm_nx[DATA_WIDTH-1-8*i -: 8] = load_byte;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= CLEAR;
    else          state <= state_nx;
  end

  // Next state
  always_comb begin
    state_nx = state;
    case (state)
      CLEAR:   if (clr_ptr == ADDR_WIDTH'(DEPTH-1)) state_nx = RUN;
      RUN:     if (load_start) state_nx = LOAD;
      LOAD:    if (load_end) state_nx = RUN;
      default: state_nx = CLEAR;
    endcase
  end

  // Outputs and write-port steering
  always_comb begin
    busy       = 1'b0;
    load_ready = 1'b0;
    rd_en      = 1'b0;
    we         = 1'b0;
    waddr      = wr_ptr;
    wdata      = asm_nx;
    case (state)
      CLEAR: begin
        busy  = 1'b1;
        we    = 1'b1;
        waddr = clr_ptr;
        wdata = HALT_WORD;
      end
      RUN: rd_en = !stall && !load_start;
      LOAD: begin
        busy       = 1'b1;
        load_ready = !full;
        we         = word_done || flush;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clr_ptr     <= '0;
      wr_ptr      <= '0;
      byte_cnt    <= '0;
      asm_q       <= '0;
      load_count  <= '0;
      load_ovf    <= 1'b0;
      instruccion <= HALT_WORD;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        CLEAR: clr_ptr <= clr_ptr + 1'b1;
        RUN: begin
          if (rd_en) begin
            instruccion <= mem[direccion];
            instr_valid <= 1'b1;
          end
          if (load_start) begin
            wr_ptr      <= '0;
            byte_cnt    <= '0;
            asm_q       <= '0;
            load_count  <= '0;
            load_ovf    <= 1'b0;
            instr_valid <= 1'b0;
          end
        end
        LOAD: begin
          instr_valid <= 1'b0;
          if (full && load_valid) load_ovf <= 1'b1;
          if (word_done || flush) begin
            wr_ptr     <= wr_ptr + 1'b1;
            load_count <= load_count + 1'b1;
            byte_cnt   <= '0;
            asm_q      <= '0;
          end else if (accept) begin
            byte_cnt <= byte_cnt + 1'b1;
            asm_q    <= asm_nx;
          end
          if (load_end) begin
            byte_cnt <= '0;
            asm_q    <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
